// File: rtl/capture_ctrl.sv
// -----------------------------------------------------------------------------
// capture_ctrl
// Sequences the switch-capture datapath. The capture button is debounced on
// both press and release. Each accepted press produces exactly one
// single-cycle enable for the switch register. When more than THRESHOLD
// switches are on, the same press also produces an enable for the event
// counter on that same cycle.
//
// Ports
//   clk50_i   in   1     system clock (50 MHz)
//   arst_i    in   1     synchronous active-high reset
//   key_n_i   in   1     raw capture button, active-low, asynchronous
//   sw_i      in   SW_W  raw switches, asynchronous
//   reg_en_o  out  1     one-cycle capture strobe to the switch register
//   cnt_en_o  out  1     one-cycle increment strobe to the event counter
//   sw_o      out  SW_W  synchronized switches (switch register d input)
//   popcnt_o  out  4     popcount latched at the last capture
//   busy_o    out  1     high whenever the controller is not idle
// -----------------------------------------------------------------------------
module capture_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,  // legal range 1..2^24-1
    parameter int unsigned SW_W            = 10,      // <= 15 for 4-bit popcount
    parameter int unsigned THRESHOLD       = 3
) (
    input  logic            clk50_i,
    input  logic            arst_i,
    input  logic            key_n_i,
    input  logic [SW_W-1:0] sw_i,
    output logic            reg_en_o,
    output logic            cnt_en_o,
    output logic [SW_W-1:0] sw_o,
    output logic [3:0]      popcnt_o,
    output logic            busy_o
);

    localparam logic [23:0] TIMER_TERM = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]  THRESH_W   = 5'(THRESHOLD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB_PRESS,
        ST_FIRE,
        ST_WAIT_REL,
        ST_DEB_REL
    } state_t;

    // Two-flop synchronizers
    logic            r_key_meta;
    logic            r_key_s;
    logic [SW_W-1:0] r_sw_meta;
    logic [SW_W-1:0] r_sw_sync;

    // FSM state and registered outputs
    state_t          r_state;
    logic [23:0]     r_timer;
    logic            r_reg_en;
    logic            r_cnt_en;
    logic [3:0]      r_popcnt;
    logic            r_busy;

    logic [3:0]      w_pop_next;

    always_ff @(posedge clk50_i) begin
        if (arst_i) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_key_meta <= key_n_i;
            r_key_s    <= r_key_meta;
            r_sw_meta  <= sw_i;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // The strobes are registered, so they are computed on the edge that
    // enters FIRE. On that same edge the first synchronizer stage moves into
    // sw_o. Counting the first stage therefore gives the popcount of the
    // value that sw_o holds during FIRE. That is the value the switch
    // register captures, so cnt_en_o and popcnt_o always agree with it,
    // even if the switches move just before the capture.
    always_comb begin
        w_pop_next = '0;
        for (int i = 0; i < int'(SW_W); i++) begin
            w_pop_next = w_pop_next + {3'b000, r_sw_meta[i]};
        end
    end

    // Each transition clears the timer, so every state is entered with
    // timer == 0. The bounce check is tested before terminal count, so a
    // level change on the terminal edge wins over the timeout.
    always_ff @(posedge clk50_i) begin
        if (arst_i) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_reg_en <= 1'b0;
            r_cnt_en <= 1'b0;
            r_popcnt <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_reg_en <= 1'b0;
            r_cnt_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_key_s) begin
                        r_state <= ST_DEB_PRESS;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_DEB_PRESS: begin
                    if (r_key_s) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_timer == TIMER_TERM) begin
                        r_state  <= ST_FIRE;
                        r_timer  <= '0;
                        r_reg_en <= 1'b1;
                        r_cnt_en <= ({1'b0, w_pop_next} > THRESH_W);
                        r_popcnt <= w_pop_next;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end

                // FIRE lasts one cycle. The default clear of the strobes
                // above drops them on the edge that leaves FIRE.
                ST_FIRE: begin
                    r_state <= ST_WAIT_REL;
                    r_timer <= '0;
                end

                ST_WAIT_REL: begin
                    if (r_key_s) begin
                        r_state <= ST_DEB_REL;
                        r_timer <= '0;
                    end
                end

                ST_DEB_REL: begin
                    if (!r_key_s) begin
                        r_state <= ST_WAIT_REL;
                        r_timer <= '0;
                    end else if (r_timer == TIMER_TERM) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_en_o = r_reg_en;
    assign cnt_en_o = r_cnt_en;
    assign sw_o     = r_sw_sync;
    assign popcnt_o = r_popcnt;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_ctrl
// Self-checking bench for capture_ctrl with DEBOUNCE_CYCLES = 4.
// Each press that should be accepted pushes an expected strobe record onto a
// queue. The record holds the cycle, cnt_en, popcount and sw_o value. A
// monitor pops one record for every reg_en_o pulse it observes and compares
// the pulse against it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_capture_ctrl;

    localparam int D    = 4;
    localparam int SW_W = 10;
    localparam int TH   = 3;

    logic            clk = 1'b0;
    logic            arst_i;
    logic            key_n_i;
    logic [SW_W-1:0] sw_i;
    logic            reg_en_o;
    logic            cnt_en_o;
    logic [SW_W-1:0] sw_o;
    logic [3:0]      popcnt_o;
    logic            busy_o;

    always #10 clk = ~clk;

    capture_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .SW_W            (SW_W),
        .THRESHOLD       (TH)
    ) dut (
        .clk50_i  (clk),
        .arst_i   (arst_i),
        .key_n_i  (key_n_i),
        .sw_i     (sw_i),
        .reg_en_o (reg_en_o),
        .cnt_en_o (cnt_en_o),
        .sw_o     (sw_o),
        .popcnt_o (popcnt_o),
        .busy_o   (busy_o)
    );

    typedef struct {
        int              cyc;
        logic            cnt;
        logic [3:0]      pop;
        logic [SW_W-1:0] sw;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int n_strobes = 0;
    int n_cnt     = 0;
    int base_s;
    int base_c;
    logic prev_reg_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reg_en_o) begin
            n_strobes++;
            if (cnt_en_o) n_cnt++;
            $display("strobe cyc=%0d sw=0x%03h pop=%0d cnt=%0b", cyc, sw_o, popcnt_o, cnt_en_o);
            chk("reg_en_width", prev_reg_en, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", reg_en_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("cnt_en", cnt_en_o, e.cnt);
                chk("popcnt", popcnt_o, e.pop);
                chk("sw_o", sw_o, e.sw);
            end
        end else if (cnt_en_o) begin
            chk("cnt_en_without_reg_en", cnt_en_o, 1'b0);
        end
        prev_reg_en = reg_en_o;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The key is sampled low at edge cyc+1. It reaches key_s one edge later,
    // the FSM enters DEB_PRESS the edge after that, and FIRE follows D edges
    // later. reg_en_o is therefore seen in the cycle after edge cyc+3+D.
    task automatic push_exp(input logic [SW_W-1:0] s);
        exp_t x;
        x.cyc = cyc + 3 + D;
        x.cnt = ($countones(s) > TH);
        x.pop = 4'($countones(s));
        x.sw  = s;
        exp_q.push_back(x);
    endtask

    task automatic press(input logic [SW_W-1:0] s, input int hold);
        sw_i = s;
        step(3);
        key_n_i = 1'b0;
        push_exp(s);
        step(hold);
        key_n_i = 1'b1;
        step(12);
        chk("busy_after_release", busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        arst_i  = 1'b1;
        key_n_i = 1'b1;
        sw_i    = 10'h3FF;
        step(3);
        chk("rst_reg_en", reg_en_o, 1'b0);
        chk("rst_cnt_en", cnt_en_o, 1'b0);
        chk("rst_popcnt", popcnt_o, 4'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_sw_o", sw_o, 10'h000);
        arst_i = 1'b0;
        step(1);
        chk("sw_sync_lat1", sw_o, 10'h000);
        step(1);
        chk("sw_sync_lat2", sw_o, 10'h3FF);

        // Clean press held for 20 cycles: 5 switches on
        base_s = n_strobes; base_c = n_cnt;
        press(10'h01F, 20);
        chk("p1_strobes", n_strobes - base_s, 1);
        chk("p1_cnt", n_cnt - base_c, 1);
        chk("p1_popcnt_hold", popcnt_o, 4'd5);

        // Threshold boundary: 3 switches on, then 4 switches on
        base_s = n_strobes; base_c = n_cnt;
        press(10'h007, 10);
        chk("th3_strobes", n_strobes - base_s, 1);
        chk("th3_cnt", n_cnt - base_c, 0);
        chk("th3_popcnt", popcnt_o, 4'd3);
        base_s = n_strobes; base_c = n_cnt;
        press(10'h00F, 10);
        chk("th4_strobes", n_strobes - base_s, 1);
        chk("th4_cnt", n_cnt - base_c, 1);
        chk("th4_popcnt", popcnt_o, 4'd4);

        // Press bounce: low 3, high 1, low 2, high 10
        base_s = n_strobes;
        key_n_i = 1'b0; step(3);
        chk("bounce_busy", busy_o, 1'b1);
        key_n_i = 1'b1; step(1);
        key_n_i = 1'b0; step(2);
        key_n_i = 1'b1; step(10);
        chk("bounce_strobes", n_strobes - base_s, 0);
        chk("bounce_idle", busy_o, 1'b0);

        // Valid press followed by release bounce
        base_s = n_strobes;
        sw_i = 10'h1F0;
        step(3);
        key_n_i = 1'b0; push_exp(10'h1F0); step(10);
        key_n_i = 1'b1; step(2);
        key_n_i = 1'b0; step(1);
        key_n_i = 1'b1; step(12);
        chk("relbounce_strobes", n_strobes - base_s, 1);
        chk("relbounce_idle", busy_o, 1'b0);

        // Back-to-back presses, all switches on
        base_s = n_strobes; base_c = n_cnt;
        for (int i = 0; i < 3; i++) begin
            press(10'h3FF, 10);
            chk("b2b_popcnt", popcnt_o, 4'd10);
        end
        chk("b2b_strobes", n_strobes - base_s, 3);
        chk("b2b_cnt", n_cnt - base_c, 3);

        // Reset in DEB_PRESS at timer=2, key held through reset release
        base_s = n_strobes;
        sw_i = 10'h0FF;
        step(3);
        key_n_i = 1'b0;
        step(5);
        chk("pre_rst_busy", busy_o, 1'b1);
        arst_i = 1'b1;
        step(1);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_reg_en", reg_en_o, 1'b0);
        chk("midrst_popcnt", popcnt_o, 4'd0);
        arst_i = 1'b0;
        push_exp(10'h0FF);
        step(14);
        key_n_i = 1'b1;
        step(12);
        chk("midrst_strobes", n_strobes - base_s, 1);

        // Reset on the edge that would enter FIRE
        base_s = n_strobes;
        sw_i = 10'h3FF;
        step(3);
        key_n_i = 1'b0;
        step(6);
        arst_i  = 1'b1;
        key_n_i = 1'b1;
        step(1);
        chk("firerst_reg_en", reg_en_o, 1'b0);
        chk("firerst_busy", busy_o, 1'b0);
        chk("firerst_popcnt", popcnt_o, 4'd0);
        step(2);
        arst_i = 1'b0;
        step(15);
        chk("firerst_strobes", n_strobes - base_s, 0);

        // Release lands on the DEB_PRESS terminal-count edge
        base_s = n_strobes;
        key_n_i = 1'b0;
        step(4);
        key_n_i = 1'b1;
        step(2);
        chk("term_busy_before", busy_o, 1'b1);
        step(1);
        chk("term_busy_after", busy_o, 1'b0);
        step(10);
        chk("term_strobes", n_strobes - base_s, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequences the switch-capture datapath: the 10-bit switch register and the 8-bit event counter.
- Debounces the active-low capture button.
- Issues exactly one single-cycle register-enable per debounced press.
- Issues a counter-enable on that same cycle only when more than THRESHOLD switches are on.
- Replaces the raw key-to-enable wiring in the board top level. Its enables drive the register and counter en_i inputs.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable-level cycles required for press and for release (10 ms at 50 MHz); legal range 1..2^24-1.
- SW_W, 10, switch vector width.
- THRESHOLD, 3, cnt_en_o fires only if popcount(switches) > THRESHOLD.

Ports:
- clk50_i  input  1  system clock, 50 MHz.
- arst_i  input  1  reset; one clock; reset is synchronous and active-high.
- key_n_i  input  1  raw capture button, active-low, asynchronous to clk50_i.
- sw_i  input  SW_W  raw switches, asynchronous.
- reg_en_o  output  1  one-cycle capture strobe to the switch register.
- cnt_en_o  output  1  one-cycle increment strobe to the event counter.
- sw_o  output  SW_W  synchronized switch value; this is the register d input.
- popcnt_o  output  4  popcount latched at the last capture.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Synchronizers:
  - 2-flop synchronizer on key_n_i; reset value 1 (released).
  - 2-flop synchronizer on sw_i; reset value 0.
  - key_s and sw_o are the second-stage outputs.
- Timer: 24-bit; cleared on every state entry.
- FSM states and transitions:
  - IDLE: key_s==0 -> DEB_PRESS.
  - DEB_PRESS: key_s==1 -> IDLE (bounce rejected). Else if timer==DEBOUNCE_CYCLES-1 -> FIRE. Else timer+1.
  - FIRE: lasts exactly one cycle.
    - reg_en_o=1.
    - cnt_en_o = (popcount(sw_o) > THRESHOLD).
    - popcnt_o <= popcount(sw_o).
    - Next state: WAIT_REL, unconditionally.
  - WAIT_REL: key_s==1 -> DEB_REL.
  - DEB_REL: key_s==0 -> WAIT_REL. Else if timer==DEBOUNCE_CYCLES-1 -> IDLE. Else timer+1.
- Strobes:
  - reg_en_o and cnt_en_o are registered, high only in FIRE, and never high for 2 consecutive cycles.
  - Holding the key generates no further strobes.
- Latency: let edge 0 be the first clock edge that samples key_n_i low, with the key held low throughout.
  - The FSM enters DEB_PRESS at edge 2.
  - It enters FIRE at edge 2+DEBOUNCE_CYCLES.
  - reg_en_o is high for the cycle between edges 2+DEBOUNCE_CYCLES and 3+DEBOUNCE_CYCLES.
- Capture value: the switch register captures sw_o on the FIRE cycle.
  - sw_o is the switch state 2 edges earlier.
  - Switch changes during debounce are allowed; the FIRE-cycle value wins.
- Popcount: unsigned sum of SW_W bits; 4 bits suffice for SW_W<=15. The compare is strictly greater (popcount 3 -> no count, 4 -> count).
- Reset (arst_i high at a clock edge, any state, including mid-debounce and FIRE):
  - state=IDLE, timer=0.
  - reg_en_o=0, cnt_en_o=0, popcnt_o=0, busy_o=0.
  - Key synchronizer=1, sw synchronizer=0.
  - A strobe scheduled for the reset edge is dropped.
  - If the key is still held after reset release, key_s falls 2 edges later and a fresh full debounce runs. That press then fires once.
- Simultaneous events:
  - Reset dominates all.
  - In DEB_PRESS, a key release on the same edge the timer hits terminal count -> IDLE, no FIRE; the bounce check has priority.
  - The same priority applies in DEB_REL: a re-press at terminal count -> WAIT_REL.
- Timer compares against DEBOUNCE_CYCLES-1 only, so there is no overflow path.
- DEBOUNCE_CYCLES=1: DEB_PRESS lasts exactly one cycle.

Test Plan:
- DEBOUNCE_CYCLES=4, sw_i=10'b00_0001_1111. Press key clean at edge 0 and hold for 20 cycles.
  - Required: reg_en_o high only for the cycle after edge 6.
  - Required: cnt_en_o=1, popcnt_o=5, sw_o=0x01F in that cycle.
  - Required: no further strobes while the key is held.
- DEBOUNCE_CYCLES=4, sw_i=10'b00_0000_0111, one clean press.
  - Required: reg_en_o pulses once, cnt_en_o stays 0, popcnt_o=3.
  - Then sw_i=0x00F and a second press. Required: cnt_en_o=1, popcnt_o=4.
- Bounce: DEBOUNCE_CYCLES=4, key low 3 cycles, high 1, low 2, high 10.
  - Required: no strobes; busy_o returns to 0.
  - Repeat with release bounces after a valid press. Required: exactly 1 strobe total.
- Reset mid-operation:
  - Assert arst_i during DEB_PRESS at timer=2. Required: busy_o=0 next cycle and no strobe.
  - Key held through reset release. Required: reg_en_o at edge 6 after release.
  - Reset asserted on the FIRE edge. Required: reg_en_o never seen.
- Back-to-back: 3 valid presses separated by valid releases, sw_i=10'h3FF.
  - Required: exactly 3 reg_en_o and 3 cnt_en_o pulses, each 1 cycle wide.
  - Required: popcnt_o=10 after each.
- Terminal-edge priority: release the key so key_s rises exactly on the DEB_PRESS terminal-count edge.
  - Required: no FIRE; state returns to IDLE.
